// File: rtl/chip8_mem_arb.sv
// chip8_mem_arb: loader/CPU/display arbiter and owner of the 4096x8 CHIP-8 main memory.
// Optional CHIP8_MEM_ARB_RR_EN selects round-robin CPU/display tie-break instead of fixed CPU priority.
module chip8_mem_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              lock_q;
  logic              rr_cpu;
  logic              cpu_win;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef CHIP8_MEM_ARB_RR_EN
  logic              last_cpu;
  assign rr_cpu = ~last_cpu;
`else
  assign rr_cpu = 1'b1;
`endif
  // A locked burst keeps the CPU ahead of the display regardless of policy
  assign cpu_win = cpu_req & (~dsp_req | lock_q | rr_cpu);
  always_comb begin
    ld_gnt  = ~rst & ld_req;
    cpu_gnt = ~rst & ~ld_req & cpu_win;
    dsp_gnt = ~rst & ~ld_req & dsp_req & ~cpu_win;
    we      = ld_gnt | (cpu_gnt & cpu_we);
    addr    = ld_gnt ? ld_addr : cpu_gnt ? cpu_addr : dsp_addr;
    wdata   = ld_gnt ? ld_wdata : cpu_wdata;
  end
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      dsp_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dsp_rdata  <= '0;
      lock_q     <= 1'b0;
`ifdef CHIP8_MEM_ARB_RR_EN
      last_cpu   <= 1'b0;
`endif
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dsp_rvalid <= dsp_gnt;
      lock_q     <= cpu_gnt & cpu_lock;
      if (cpu_gnt & ~cpu_we) cpu_rdata <= mem[addr];
      if (dsp_gnt) dsp_rdata <= mem[addr];
`ifdef CHIP8_MEM_ARB_RR_EN
      if (cpu_gnt) last_cpu <= 1'b1;
      else if (dsp_gnt) last_cpu <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_chip8_mem_arb.sv
// tb_chip8_mem_arb: randomized and directed scoreboard bench for chip8_mem_arb against a behavioural model.
module tb_chip8_mem_arb;
`ifdef CHIP8_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        ld_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0, dsp_req = 1'b0;
  logic [11:0] ld_addr = '0, cpu_addr = '0, dsp_addr = '0;
  logic [7:0]  ld_wdata = '0, cpu_wdata = '0;
  logic        ld_gnt, cpu_gnt, dsp_gnt, cpu_rvalid, dsp_rvalid;
  logic [7:0]  cpu_rdata, dsp_rdata;

  chip8_mem_arb dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid),
    .dsp_rdata(dsp_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [7:0] ref_mem [4096];
  logic [7:0] cpu_q[$], dsp_q[$];
  logic [7:0] cpu_held = '0, dsp_held = '0;
  int eg = 0;
  bit cpu_recent = 0, locked = 0, rst_seen = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected winner from the arbitration rules (0 none, 1 loader, 2 cpu, 3 display)
  initial forever begin
    @(negedge clk);
    if (rst) eg = 0;
    else if (ld_req) eg = 1;
    else if (cpu_req && (!dsp_req || locked || !RR || !cpu_recent)) eg = 2;
    else if (dsp_req) eg = 3;
    else eg = 0;
    chk("grant", {ld_gnt, cpu_gnt, dsp_gnt}, eg == 1 ? 4 : eg == 2 ? 2 : eg == 3 ? 1 : 0);
  end

  initial forever begin
    @(posedge clk);
    rst_seen = rst;
    if (rst) begin
      locked = 0;
      cpu_recent = 0;
    end else begin
      locked = (eg == 2) && cpu_lock;
      if (eg == 1) ref_mem[ld_addr] = ld_wdata;
      if (eg == 2) begin
        cpu_recent = 1;
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else cpu_q.push_back(ref_mem[cpu_addr]);
      end
      if (eg == 3) begin
        cpu_recent = 0;
        dsp_q.push_back(ref_mem[dsp_addr]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_seen) begin
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dsp_rvalid", dsp_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dsp_rdata", dsp_rdata, 0);
      cpu_held = '0;
      dsp_held = '0;
      cpu_q.delete();
      dsp_q.delete();
    end else begin
      chk("cpu_rvalid", cpu_rvalid, cpu_q.size() != 0);
      if (cpu_q.size() != 0) begin
        cpu_held = cpu_q.pop_front();
        if (cpu_rvalid === 1'b1) chk("cpu_rdata", cpu_rdata, cpu_held);
      end else chk("cpu_rdata_hold", cpu_rdata, cpu_held);
      chk("dsp_rvalid", dsp_rvalid, dsp_q.size() != 0);
      if (dsp_q.size() != 0) begin
        dsp_held = dsp_q.pop_front();
        if (dsp_rvalid === 1'b1) chk("dsp_rdata", dsp_rdata, dsp_held);
      end else chk("dsp_rdata_hold", dsp_rdata, dsp_held);
    end
  end

  function automatic logic [11:0] addr_of(input int r);
    return r < 16 ? 12'(r) : r == 16 ? 12'h050 : r == 17 ? 12'h200 :
           r < 22 ? 12'(12'h300 + r - 18) : 12'(12'hFFE + r - 22);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_wr(input logic [11:0] a, input logic [7:0] d);
    ld_req = 1; ld_addr = a; ld_wdata = d;
    tick();
    ld_req = 0;
  endtask

  task automatic cpu_op(input logic we, input logic [11:0] a, input logic [7:0] d, input logic lk);
    bit got = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_lock = lk;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (eg == 2);
    end
    chk("cpu_op_granted", got, 1);
    cpu_req = 0; cpu_lock = 0;
  endtask

  task automatic dsp_op(input logic [11:0] a);
    bit got = 0;
    dsp_req = 1; dsp_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (eg == 3);
    end
    chk("dsp_op_granted", got, 1);
    dsp_req = 0;
  endtask

  initial begin
    bit pl = 0, pc = 0, pd = 0;
    ld_req = 1; cpu_req = 1; dsp_req = 1; ld_addr = 12'h200; cpu_addr = 12'h200; dsp_addr = 12'h200;
    repeat (3) tick();
    rst = 0; ld_req = 0; cpu_req = 0; dsp_req = 0;
    tick();
    ld_wr(12'h200, 8'hAB);
    cpu_op(0, 12'h200, 8'h00, 0);
    tick();
    for (int r = 0; r < 24; r++) ld_wr(addr_of(r), 8'($urandom));
    ld_req = 1; cpu_req = 1; dsp_req = 1; ld_addr = 12'h00A; ld_wdata = 8'h5A;
    cpu_we = 0; cpu_addr = 12'h050; dsp_addr = 12'h300;
    for (int i = 0; i < 3; i++) begin
      #3 chk("ld_prio", {ld_gnt, cpu_gnt, dsp_gnt}, 3'b100);
      tick();
    end
    ld_req = 0; cpu_req = 0; dsp_req = 0;
    dsp_op(12'h000);
    cpu_req = 1; dsp_req = 1; cpu_we = 0; cpu_addr = 12'h050; dsp_addr = 12'h300;
    for (int i = 0; i < 8; i++) begin
      #3 chk("alternate", {cpu_gnt, dsp_gnt}, (RR && i % 2 == 1) ? 2'b01 : 2'b10);
      tick();
    end
    cpu_req = 0; dsp_req = 0;
    tick();
    dsp_op(12'h000);
    dsp_req = 1; dsp_addr = 12'h001;
    for (int k = 0; k < 4; k++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 12'(12'h300 + k); cpu_wdata = 8'(k + 1); cpu_lock = (k < 3);
      #3 chk("burst_cpu_gnt", cpu_gnt, 1);
      tick();
    end
    cpu_req = 0; cpu_lock = 0;
    #3 chk("burst_dsp_gnt", dsp_gnt, 1);
    tick();
    dsp_req = 0;
    for (int k = 0; k < 4; k++) cpu_op(0, 12'(12'h300 + k), 8'h00, 0);
    rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h300;
    tick();
    rst = 0; cpu_req = 0;
    tick();
    cpu_op(0, 12'h301, 8'h00, 0);
    cpu_op(0, 12'h200, 8'h00, 0);
    for (int c = 0; c < 400; c++) begin
      if (!pl && $urandom_range(7) == 0) begin
        pl = 1; ld_req = 1; ld_addr = addr_of($urandom_range(23)); ld_wdata = 8'($urandom);
      end
      if (!pc && $urandom_range(1) == 0) begin
        pc = 1; cpu_req = 1; cpu_we = 1'($urandom); cpu_lock = ($urandom_range(3) == 0);
        cpu_addr = addr_of($urandom_range(23)); cpu_wdata = 8'($urandom);
      end
      if (!pd && $urandom_range(1) == 0) begin
        pd = 1; dsp_req = 1; dsp_addr = addr_of($urandom_range(23));
      end
      tick();
      if (eg == 1) begin pl = 0; ld_req = 0; end
      if (eg == 2) begin pc = 0; cpu_req = 0; cpu_lock = 0; end
      if (eg == 3) begin pd = 0; dsp_req = 0; end
    end
    ld_req = 0; cpu_req = 0; dsp_req = 0; cpu_lock = 0;
    repeat (3) tick();
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dsp_q_drained", dsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/chip8_mem_arb.md
# chip8_mem_arb

Arbiter and owner of the 4096 x 8 main memory of the CHIP-8 core. It shares the single-port array between three requesters: the ROM/font loader, the CPU (fetch and execute, including FX55/FX65 bursts) and the display engine (DXYN sprite reads). Grants are issued combinationally and the access is performed at the next clock edge. Read data returns one cycle later on the granted requester's port. The block sits between `cpu` and the memory array; the CPU no longer declares its own memory.

## Interface
Parameters:
- `ADDR_W`, 12: address width; array depth is 2**ADDR_W.
- `DATA_W`, 8: data width (`u8`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_req`  in  1  loader write request; write-only port.
- `ld_addr`  in  ADDR_W  loader address.
- `ld_wdata`  in  DATA_W  loader write data.
- `ld_gnt`  out  1  loader granted this cycle.
- `cpu_req`  in  1  CPU request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_lock`  in  1  hold priority over display on the next cycle (bursts).
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  CPU granted this cycle.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DATA_W  CPU read data.
- `dsp_req`  in  1  display read request.
- `dsp_addr`  in  ADDR_W  display address.
- `dsp_gnt`  out  1  display granted this cycle.
- `dsp_rvalid`  out  1  display read data valid.
- `dsp_rdata`  out  DATA_W  display read data.

## Operation
- At most one grant per cycle; gnt outputs are one-hot or all zero.
- Requesters hold `*_req` and operands stable until their gnt is seen.
- Loader has absolute priority whenever `ld_req` = 1.
- CPU vs display tie-break:
  - Lock rule: if the CPU was granted last cycle and `cpu_lock` was 1 in that cycle, the CPU wins this cycle.
  - Otherwise the tie is broken by the arbitration policy (see Configuration).
- `last_cpu` flag: set when the CPU is granted, cleared when the display is granted. It is unchanged on loader grants and idle cycles.
- Granted write: the array is written at the clock edge. No rvalid is produced.
- Granted read: the array is read at the clock edge. The requester's `rvalid` is 1 for exactly the next cycle, with `rdata` held.
- `rdata` keeps its last value when `rvalid` = 0.
- Read after a write to the same address in a later cycle returns the new data. Same-cycle read and write cannot occur.
- Addresses are ADDR_W bits. There is no wrap logic; requesters wrap 0xFFF to 0x000 themselves.
- Reset:
  - All gnt = 0 while `rst` = 1. `cpu_rvalid` = 0, `dsp_rvalid` = 0, `cpu_rdata` = 0, `dsp_rdata` = 0.
  - `last_cpu` = 0 and the lock state is cleared.
  - Memory contents are not cleared.
  - A read granted in the cycle `rst` rises produces no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as req when the requester wins).
- Read latency: 1 cycle from the grant edge to `rvalid`.
- Throughput: one access per cycle, sustained.
- Display worst-case wait under round-robin with no loader and no CPU lock: 1 cycle.
- A CPU lock burst of N accesses delays the display by up to N cycles.

## Configuration
- `CHIP8_MEM_ARB_RR_EN` defined: round-robin policy. When CPU and display tie and no lock applies, the one not granted most recently wins (`last_cpu` = 1 means display wins). After reset the CPU wins the first tie.
- Undefined: fixed priority. CPU always beats display; `last_cpu` is unused. Lock behaviour is unchanged.

## Test plan
- Reset: assert `rst` with all reqs high → all gnt = 0 and both rvalid = 0. After release, a write of 0xAB to 0x200 by the loader then a CPU read of 0x200 → `cpu_rvalid` = 1 one cycle after `cpu_gnt`, `cpu_rdata` = 0xAB.
- Loader priority: `ld_req`, `cpu_req` and `dsp_req` all high for 3 cycles → `ld_gnt` for all 3 cycles and no other gnt.
- Round-robin (macro defined): CPU and display read continuously from 0x050 and 0x300 → grants alternate CPU, display, CPU, …, starting with CPU. Each rvalid returns the matching byte.
- Fixed priority (macro undefined): same stimulus as round-robin → `cpu_gnt` every cycle, `dsp_gnt` never.
- CPU lock burst: CPU writes 0x01..0x04 to 0x300..0x303 with `cpu_lock` = 1 on the first three, display requesting throughout → 4 consecutive `cpu_gnt`, then `dsp_gnt`. Subsequent reads of 0x300..0x303 return 0x01..0x04.
- Reset mid-read: CPU read granted in the cycle `rst` rises → `cpu_rvalid` stays 0. Memory contents written before reset read back unchanged after reset.
